pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the RV64I core.
- Successor to the fixed per-field hold/flush DFF stages. Replaces them with one payload register carrying a valid/ready handshake, level-encoded hold, flush-to-bubble and occupancy tracking.
- Instantiated between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB) with a per-stage STAGE_IDX.

Parameters:
- DW, 64: payload width in bits; callers concatenate their fields.
- HOLD_W, 3: width of the hold-level bus from the hazard controller.
- STAGE_IDX, 3: stage holds when hold_level_i >= STAGE_IDX; 0 is illegal.
- BUBBLE_VAL, {DW{1'b0}}: payload driven when empty, flushed or in reset (e.g. NOP encoding in the instruction field).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid_i  in  1  upstream payload valid.
- in_ready_o  out  1  stage can accept the payload this cycle.
- in_data_i  in  DW  upstream payload.
- out_valid_o  out  1  registered payload valid.
- out_ready_i  in  1  downstream accepts the payload.
- out_data_o  out  DW  registered payload.
- hold_level_i  in  HOLD_W  hazard-controller stall level.
- flush_i  in  1  discard all contents and insert a bubble.
- occ_o  out  2  entries held (0..1 without skid, 0..2 with skid).

Interface rule (already decided): one clock, clk; reset is synchronous and active-high, port rst.

Behaviour:
- held = (hold_level_i >= STAGE_IDX), unsigned compare.
- Transfers:
  - In-transfer = in_valid_i & in_ready_o.
  - Out-transfer = out_valid_o & out_ready_i & ~held.
- Latency: 1 cycle from in-transfer to out_valid_o when the stage is empty.
- Priority: rst > flush_i > held > normal.
- Reset, for every cycle rst is high and on the following edge:
  - out_valid_o=0, out_data_o=BUBBLE_VAL, occ_o=0, skid entry cleared.
  - in_ready_o=0 while rst is high.
- Flush:
  - On the edge after flush_i=1, the same values as reset apply.
  - An in-transfer coincident with flush_i is discarded.
  - in_ready_o stays 1 during flush unless held or in reset; the upstream sees the beat as consumed.
- Held:
  - in_ready_o=0; no out-transfer.
  - out_valid_o, out_data_o and occ_o are frozen.
  - Flush still wins over held.
- When empty, out_data_o equals BUBBLE_VAL. Downstream may decode it without checking valid.
- Main state machine (base build, no skid):
  - EMPTY: on in-transfer go to FULL and load data.
  - FULL: on out-transfer without in-transfer go to EMPTY and load BUBBLE_VAL. On out-transfer with in-transfer stay FULL and load new data. Otherwise stay.
  - in_ready_o = ~held & (~out_valid_o | out_ready_i). This is a combinational path from out_ready_i.
- Simultaneous in and out transfer in FULL sustains 1 beat/cycle with no bubble.
- occ_o always equals the number of valid entries; it never exceeds the configured capacity.

Optional Feature:
- Macro: PIPE_STAGE_SKID_EN.
- When defined, a one-entry skid buffer is added and the state machine gains a SKID state (main + skid valid).
- in_ready_o = ~held & ~skid_valid. The path from out_ready_i is cut: only a registered term plus held.
- FULL with in-transfer and no out-transfer goes to SKID; the new beat is stored in skid.
- SKID on out-transfer goes to FULL; the skid entry moves to main.
- SKID accepts no in-transfer.
- Flush and reset clear both entries. occ_o reaches 2.
- Without the macro: base build only; occ_o is never 2.
- Full throughput (1 beat/cycle) is required in both builds.

Decomposition:
- Shared package pipe_pkg:
  - hold-level constants HOLD_NONE=0, HOLD_PC=1, HOLD_IF=2, HOLD_ID=3, HOLD_EX=4;
  - NOP instruction constant (32'h00000013);
  - stage-state enum (ST_EMPTY, ST_FULL, ST_SKID).
- Natural sub-module pipe_skid_buf: one data/valid entry with load/clear. It is instantiated only under PIPE_STAGE_SKID_EN.

Test Plan (DW=32, STAGE_IDX=3, BUBBLE_VAL=32'h00000013):
- Basic flow: rst high 2 cycles, then in_valid_i=1 with data 32'hA0 and out_ready_i=1 → out_valid_o=1 and out_data_o=32'hA0 one cycle later; before that out_data_o=32'h13 and occ_o=0.
- Back-to-back: stream 32'h1..32'h8 with out_ready_i=1 → 8 consecutive output beats, no gaps, order preserved.
- Hold threshold: FULL with 32'hB0, hold_level_i=3 for 4 cycles → in_ready_o=0 and output frozen at 32'hB0. With hold_level_i=2 the stage is not held.
- Flush over hold: FULL with 32'hC0, hold_level_i=4 and flush_i=1 in the same cycle → next cycle out_valid_o=0, out_data_o=32'h13, occ_o=0.
- Backpressure (skid build): out_ready_i=0, send 32'hD0 then 32'hD1 → occ_o=2 and in_ready_o=0. Raise out_ready_i → D0 then D1 in order, occ_o returns to 0.
- Reset mid-operation: occ_o=2 and rst pulsed 1 cycle → all outputs at reset values the next cycle; the first post-reset beat passes with latency 1.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and stage-state type for the RV64I pipeline registers
package pipe_pkg;

    localparam logic [2:0] HOLD_NONE = 3'd0;
    localparam logic [2:0] HOLD_PC   = 3'd1;
    localparam logic [2:0] HOLD_IF   = 3'd2;
    localparam logic [2:0] HOLD_ID   = 3'd3;
    localparam logic [2:0] HOLD_EX   = 3'd4;

    localparam logic [31:0] NOP_INSN = 32'h00000013;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state_e;

    function automatic logic [1:0] state_occ(input stage_state_e s);
        case (s)
            ST_FULL: state_occ = 2'd1;
            ST_SKID: state_occ = 2'd2;
            default: state_occ = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - single data/valid entry with load and clear
module pipe_skid_buf #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          clear,
    input  logic [DW-1:0] load_data,
    output logic          valid,
    output logic [DW-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage pipeline register with hold, flush and optional skid (PIPE_STAGE_SKID_EN)
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int              DW         = 64,
    parameter int              HOLD_W     = 3,
    parameter int              STAGE_IDX  = 3,
    parameter logic [DW-1:0]   BUBBLE_VAL = {DW{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DW-1:0]     in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DW-1:0]     out_data_o,
    input  logic [HOLD_W-1:0] hold_level_i,
    input  logic              flush_i,
    output logic [1:0]        occ_o
);

    localparam logic [31:0] STAGE_THR = STAGE_IDX;

    stage_state_e  state_q, state_d;
    logic [DW-1:0] main_q, main_d;
    logic          held;
    logic          in_xfer;
    logic          out_xfer;

    // Zero-extend before comparing so a STAGE_IDX beyond the bus range never truncates.
    assign held = ({{(32-HOLD_W){1'b0}}, hold_level_i} >= STAGE_THR);

`ifdef PIPE_STAGE_SKID_EN
    logic          skid_valid;
    logic          skid_load;
    logic          skid_clear;
    logic [DW-1:0] skid_data;

    pipe_skid_buf #(
        .DW(DW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .clear     (skid_clear),
        .load_data (in_data_i),
        .valid     (skid_valid),
        .data      (skid_data)
    );

    // Registered term only: out_ready_i never reaches in_ready_o here.
    assign in_ready_o = ~rst & ~held & (flush_i | ~skid_valid);
`else
    assign in_ready_o = ~rst & ~held & (flush_i | ~out_valid_o | out_ready_i);
`endif

    assign out_valid_o = (state_q != ST_EMPTY);
    assign out_data_o  = main_q;
    assign occ_o       = state_occ(state_q);

    assign in_xfer  = in_valid_i & in_ready_o;
    assign out_xfer = out_valid_o & out_ready_i & ~held;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_load  = 1'b0;
        skid_clear = 1'b0;
`endif
        if (flush_i) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE_VAL;
`ifdef PIPE_STAGE_SKID_EN
            skid_clear = 1'b1;
`endif
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d = ST_FULL;
                        main_d  = in_data_i;
                    end
                end
                ST_FULL: begin
                    if (out_xfer && in_xfer) begin
                        main_d = in_data_i;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                        main_d  = BUBBLE_VAL;
                    end
`ifdef PIPE_STAGE_SKID_EN
                    else if (in_xfer) begin
                        state_d   = ST_SKID;
                        skid_load = 1'b1;
                    end
`endif
                end
`ifdef PIPE_STAGE_SKID_EN
                ST_SKID: begin
                    if (out_xfer) begin
                        state_d    = ST_FULL;
                        main_d     = skid_data;
                        skid_clear = 1'b1;
                    end
                end
`endif
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE_VAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

endmodule
